// File: rtl/writeback_queue.sv
// Write-back merge stage: round-robin admission of producer results into a
// small FIFO that feeds the register-file write port and the NZP generator.
module writeback_queue #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 3,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*WIDTH-1:0]      src_data,
    input  logic [NUM_SRC*REG_BITS-1:0]   src_dest,
    input  logic [NUM_SRC-1:0]            src_ld_reg,
    input  logic [NUM_SRC-1:0]            src_ld_cc,
    input  logic                          stall,
    output logic [WIDTH-1:0]              reg_data,
    output logic [REG_BITS-1:0]           dest_reg,
    output logic                          ld_reg_store,
    output logic                          ld_cc_store,
    output logic [2:0]                    gencc_out,
    output logic [(2**REG_BITS)-1:0]      pending_mask,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          full,
    output logic                          empty
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH+1);
    localparam int SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int NUM_REGS = 2**REG_BITS;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC-1);

    logic [WIDTH-1:0]    r_data [DEPTH];
    logic [REG_BITS-1:0] r_dest [DEPTH];
    logic [DEPTH-1:0]    r_ld_reg;
    logic [DEPTH-1:0]    r_ld_cc;
    logic [DEPTH-1:0]    r_vld;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic [SRC_W-1:0]    r_last;

    logic                w_grant_any;
    logic [SRC_W-1:0]    w_grant_idx;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_space;
    logic                w_accept;
    logic                w_push;
    logic [WIDTH-1:0]    w_sel_data;
    logic [REG_BITS-1:0] w_sel_dest;
    logic                w_sel_ld_reg;
    logic                w_sel_ld_cc;
    logic [PTR_W-1:0]    w_head_inc;
    logic [PTR_W-1:0]    w_tail_inc;
    logic [NUM_REGS-1:0] w_entry_mask [DEPTH];

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // Reset suppresses the drain so a reset cycle never issues a write.
    assign w_pop   = !reset && !w_empty && !stall;
    assign w_space = !w_full || w_pop;

    always_comb begin
        logic [SRC_W-1:0] v_cand;
        w_grant_any = 1'b0;
        w_grant_idx = r_last;
        v_cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            v_cand = SRC_W'((int'(r_last) + k) % NUM_SRC);
            if (!w_grant_any && src_valid[v_cand]) begin
                w_grant_any = 1'b1;
                w_grant_idx = v_cand;
            end
        end
    end

    assign w_accept     = !reset && w_grant_any && w_space;
    assign w_sel_data   = src_data[w_grant_idx*WIDTH +: WIDTH];
    assign w_sel_dest   = src_dest[w_grant_idx*REG_BITS +: REG_BITS];
    assign w_sel_ld_reg = src_ld_reg[w_grant_idx];
    assign w_sel_ld_cc  = src_ld_cc[w_grant_idx];
    // Results that write nothing are acknowledged but never occupy a slot.
    assign w_push       = w_accept && (w_sel_ld_reg || w_sel_ld_cc);

    always_comb begin
        src_ready = '0;
        if (w_accept) begin
            src_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_head_inc = (r_head == LAST_PTR) ? '0 : r_head + 1'b1;
    assign w_tail_inc = (r_tail == LAST_PTR) ? '0 : r_tail + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_last  <= LAST_SRC;
        end else begin
            if (w_pop) begin
                r_head <= w_head_inc;
            end
            if (w_push) begin
                r_tail <= w_tail_inc;
            end
            if (w_accept) begin
                r_last <= w_grant_idx;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // At full with push and pop together, tail equals head: the push must win.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_data[e] <= '0;
                r_dest[e] <= '0;
            end
            r_ld_reg <= '0;
            r_ld_cc  <= '0;
            r_vld    <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_push && (r_tail == PTR_W'(e))) begin
                    r_data[e]   <= w_sel_data;
                    r_dest[e]   <= w_sel_dest;
                    r_ld_reg[e] <= w_sel_ld_reg;
                    r_ld_cc[e]  <= w_sel_ld_cc;
                    r_vld[e]    <= 1'b1;
                end else if (w_pop && (r_head == PTR_W'(e))) begin
                    r_vld[e] <= 1'b0;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry_mask
            assign w_entry_mask[gi] = (r_vld[gi] && r_ld_reg[gi])
                                      ? (NUM_REGS'(1) << r_dest[gi]) : '0;
        end
    endgenerate

    always_comb begin
        pending_mask = '0;
        for (int e = 0; e < DEPTH; e++) begin
            pending_mask = pending_mask | w_entry_mask[e];
        end
    end

    assign reg_data     = r_data[r_head];
    assign dest_reg     = r_dest[r_head];
    assign ld_reg_store = w_pop && r_ld_reg[r_head];
    assign ld_cc_store  = w_pop && r_ld_cc[r_head];
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;

    always_comb begin
        gencc_out = 3'b001;
        if (reg_data[WIDTH-1]) begin
            gencc_out = 3'b100;
        end else if (reg_data == '0) begin
            gencc_out = 3'b010;
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (WIDTH 16, REG_BITS 3, NUM_SRC 2, DEPTH 4):
// reset, single result, round robin, stall fill, dropped entries, mid-stream reset.
module tb_writeback_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  src_valid;
    logic [1:0]  src_ready;
    logic [31:0] src_data;
    logic [5:0]  src_dest;
    logic [1:0]  src_ld_reg;
    logic [1:0]  src_ld_cc;
    logic        stall;
    logic [15:0] reg_data;
    logic [2:0]  dest_reg;
    logic        ld_reg_store;
    logic        ld_cc_store;
    logic [2:0]  gencc_out;
    logic [7:0]  pending_mask;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int n_total = 0;
    int n_pass  = 0;

    writeback_queue #(.WIDTH(16), .REG_BITS(3), .NUM_SRC(2), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .src_dest(src_dest), .src_ld_reg(src_ld_reg), .src_ld_cc(src_ld_cc),
        .stall(stall), .reg_data(reg_data), .dest_reg(dest_reg),
        .ld_reg_store(ld_reg_store), .ld_cc_store(ld_cc_store),
        .gencc_out(gencc_out), .pending_mask(pending_mask), .count(count),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [15:0] d, input logic [2:0] r,
                           input logic lr, input logic lc);
        src_valid[s]        = 1'b1;
        src_data[s*16 +: 16] = d;
        src_dest[s*3 +: 3]   = r;
        src_ld_reg[s]        = lr;
        src_ld_cc[s]         = lc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        src_valid = 2'b11;
        #1;
        n_total++; if (src_ready !== 2'b00) $display("FAIL rst_ready: got %b exp 00", src_ready); else n_pass++;
        n_total++; if (reg_data !== 16'h0) $display("FAIL rst_data: got %h exp 0000", reg_data); else n_pass++;
        n_total++; if (gencc_out !== 3'b010) $display("FAIL rst_cc: got %b exp 010", gencc_out); else n_pass++;
        n_total++; if (pending_mask !== 8'h00) $display("FAIL rst_pend: got %h exp 00", pending_mask); else n_pass++;
        n_total++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL rst_flags: got e%b f%b exp e1 f0", empty, full); else n_pass++;
        n_total++; if (ld_reg_store !== 1'b0 || ld_cc_store !== 1'b0) $display("FAIL rst_ld: got %b%b exp 00", ld_reg_store, ld_cc_store); else n_pass++;
        $display("reset: ready=%b data=%h cc=%b pend=%h empty=%b", src_ready, reg_data, gencc_out, pending_mask, empty);
        src_valid = 2'b00;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_src(0, 16'h8001, 3'd3, 1'b1, 1'b1);
        #1;
        n_total++; if (src_ready !== 2'b01) $display("FAIL single_ready: got %b exp 01", src_ready); else n_pass++;
        tick();
        src_valid = 2'b00;
        #1;
        n_total++; if (ld_reg_store !== 1'b1 || ld_cc_store !== 1'b1) $display("FAIL single_ld: got %b%b exp 11", ld_reg_store, ld_cc_store); else n_pass++;
        n_total++; if (dest_reg !== 3'd3 || reg_data !== 16'h8001) $display("FAIL single_head: got %0d/%h exp 3/8001", dest_reg, reg_data); else n_pass++;
        n_total++; if (gencc_out !== 3'b100) $display("FAIL single_cc: got %b exp 100", gencc_out); else n_pass++;
        n_total++; if (pending_mask !== 8'h08) $display("FAIL single_pend1: got %h exp 08", pending_mask); else n_pass++;
        $display("single: ld=%b%b dest=%0d data=%h cc=%b pend=%h", ld_reg_store, ld_cc_store, dest_reg, reg_data, gencc_out, pending_mask);
        tick();
        n_total++; if (pending_mask !== 8'h00 || empty !== 1'b1) $display("FAIL single_pend2: got %h e%b exp 00 e1", pending_mask, empty); else n_pass++;
        n_total++; if (ld_reg_store !== 1'b0) $display("FAIL single_ld2: got %b exp 0", ld_reg_store); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ready [4];
        logic [2:0] exp_dest  [4];
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_ready[0] = 2'b01; exp_ready[1] = 2'b10; exp_ready[2] = 2'b01; exp_ready[3] = 2'b10;
        exp_dest[0] = 3'd1;   exp_dest[1] = 3'd6;   exp_dest[2] = 3'd1;   exp_dest[3] = 3'd6;
        set_src(0, 16'h0011, 3'd1, 1'b1, 1'b0);
        set_src(1, 16'h0066, 3'd6, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++; if (src_ready !== exp_ready[i]) $display("FAIL rr_grant%0d: got %b exp %b", i, src_ready, exp_ready[i]); else n_pass++;
            if (i > 0) begin
                n_total++; if (ld_reg_store !== 1'b1 || dest_reg !== exp_dest[i-1]) $display("FAIL rr_write%0d: got ld%b d%0d exp ld1 d%0d", i, ld_reg_store, dest_reg, exp_dest[i-1]); else n_pass++;
            end
            $display("rr cycle %0d: ready=%b ld=%b dest=%0d count=%0d", i, src_ready, ld_reg_store, dest_reg, count);
            tick();
        end
        src_valid = 2'b00;
        #1;
        n_total++; if (ld_reg_store !== 1'b1 || dest_reg !== exp_dest[3]) $display("FAIL rr_write_last: got ld%b d%0d exp ld1 d%0d", ld_reg_store, dest_reg, exp_dest[3]); else n_pass++;
        tick();
    endtask

    task automatic test_stall_fill();
        logic [15:0] vdata [5];
        logic [2:0]  vcc   [5];
        vdata[0] = 16'h0000; vcc[0] = 3'b010;
        vdata[1] = 16'h0005; vcc[1] = 3'b001;
        vdata[2] = 16'h1234; vcc[2] = 3'b001;
        vdata[3] = 16'hFFFF; vcc[3] = 3'b100;
        vdata[4] = 16'h7000; vcc[4] = 3'b001;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_src(0, vdata[i], 3'(i), 1'b1, 1'b1);
            #1;
            n_total++; if (src_ready !== 2'b01) $display("FAIL fill_ready%0d: got %b exp 01", i, src_ready); else n_pass++;
            tick();
        end
        set_src(0, vdata[4], 3'd4, 1'b1, 1'b1);
        #1;
        n_total++; if (full !== 1'b1 || count !== 3'd4) $display("FAIL fill_full: got f%b c%0d exp f1 c4", full, count); else n_pass++;
        n_total++; if (src_ready !== 2'b00) $display("FAIL fill_block: got %b exp 00", src_ready); else n_pass++;
        n_total++; if (ld_reg_store !== 1'b0 || ld_cc_store !== 1'b0) $display("FAIL fill_stall_ld: got %b%b exp 00", ld_reg_store, ld_cc_store); else n_pass++;
        tick();
        n_total++; if (src_ready !== 2'b00 || count !== 3'd4) $display("FAIL fill_block2: got r%b c%0d exp r00 c4", src_ready, count); else n_pass++;
        stall = 1'b0;
        #1;
        n_total++; if (src_ready !== 2'b01 || ld_reg_store !== 1'b1) $display("FAIL fill_release: got r%b ld%b exp r01 ld1", src_ready, ld_reg_store); else n_pass++;
        n_total++; if (reg_data !== vdata[0] || gencc_out !== vcc[0]) $display("FAIL fill_head0: got %h/%b exp %h/%b", reg_data, gencc_out, vdata[0], vcc[0]); else n_pass++;
        $display("stall release: ready=%b ld=%b data=%h cc=%b count=%0d", src_ready, ld_reg_store, reg_data, gencc_out, count);
        tick();
        src_valid = 2'b00;
        n_total++; if (count !== 3'd4) $display("FAIL fill_pushpop: got %0d exp 4", count); else n_pass++;
        for (int j = 1; j < 5; j++) begin
            n_total++; if (reg_data !== vdata[j] || dest_reg !== 3'(j) || gencc_out !== vcc[j] || ld_reg_store !== 1'b1)
                $display("FAIL drain%0d: got %h d%0d cc%b ld%b exp %h d%0d cc%b ld1", j, reg_data, dest_reg, gencc_out, ld_reg_store, vdata[j], j, vcc[j]);
            else n_pass++;
            $display("drain %0d: data=%h dest=%0d cc=%b count=%0d", j, reg_data, dest_reg, gencc_out, count);
            tick();
        end
        n_total++; if (empty !== 1'b1 || ld_reg_store !== 1'b0) $display("FAIL drain_end: got e%b ld%b exp e1 ld0", empty, ld_reg_store); else n_pass++;
    endtask

    task automatic test_dropped();
        set_src(0, 16'h0055, 3'd5, 1'b0, 1'b0);
        #1;
        n_total++; if (src_ready !== 2'b01) $display("FAIL drop_ack: got %b exp 01", src_ready); else n_pass++;
        tick();
        n_total++; if (count !== 3'd0 || ld_reg_store !== 1'b0 || pending_mask !== 8'h00) $display("FAIL drop_noslot: got c%0d ld%b p%h exp c0 ld0 p00", count, ld_reg_store, pending_mask); else n_pass++;
        set_src(1, 16'h0077, 3'd7, 1'b0, 1'b0);
        #1;
        n_total++; if (src_ready !== 2'b10) $display("FAIL drop_rr: got %b exp 10", src_ready); else n_pass++;
        tick();
        src_valid = 2'b00;
        stall = 1'b1;
        set_src(0, 16'h0A0A, 3'd2, 1'b1, 1'b0);
        tick();
        set_src(0, 16'h0B0B, 3'd2, 1'b1, 1'b0);
        tick();
        src_valid = 2'b00;
        #1;
        n_total++; if (count !== 3'd2 || pending_mask !== 8'h04) $display("FAIL dup_queued: got c%0d p%h exp c2 p04", count, pending_mask); else n_pass++;
        stall = 1'b0;
        #1;
        n_total++; if (ld_reg_store !== 1'b1 || reg_data !== 16'h0A0A) $display("FAIL dup_pop1: got ld%b %h exp ld1 0a0a", ld_reg_store, reg_data); else n_pass++;
        tick();
        n_total++; if (pending_mask !== 8'h04 || count !== 3'd1) $display("FAIL dup_hold: got p%h c%0d exp p04 c1", pending_mask, count); else n_pass++;
        $display("dup dest2: after first pop pend=%h count=%0d data=%h", pending_mask, count, reg_data);
        tick();
        n_total++; if (pending_mask !== 8'h00 || empty !== 1'b1) $display("FAIL dup_clear: got p%h e%b exp p00 e1", pending_mask, empty); else n_pass++;
    endtask

    task automatic test_reset_mid();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_src(0, 16'h0100 + 16'(i), 3'd7, 1'b1, 1'b1);
            tick();
        end
        src_valid = 2'b00;
        #1;
        n_total++; if (count !== 3'd3 || pending_mask !== 8'h80) $display("FAIL mid_queued: got c%0d p%h exp c3 p80", count, pending_mask); else n_pass++;
        stall = 1'b0;
        reset = 1'b1;
        #1;
        n_total++; if (ld_reg_store !== 1'b0) $display("FAIL mid_rst_ld: got %b exp 0", ld_reg_store); else n_pass++;
        tick();
        reset = 1'b0;
        #1;
        n_total++; if (count !== 3'd0 || pending_mask !== 8'h00 || empty !== 1'b1) $display("FAIL mid_cleared: got c%0d p%h e%b exp c0 p00 e1", count, pending_mask, empty); else n_pass++;
        n_total++; if (ld_reg_store !== 1'b0 || reg_data !== 16'h0) $display("FAIL mid_nowrite: got ld%b %h exp ld0 0000", ld_reg_store, reg_data); else n_pass++;
        $display("mid reset: count=%0d pend=%h ld=%b", count, pending_mask, ld_reg_store);
        tick();
        n_total++; if (ld_reg_store !== 1'b0) $display("FAIL mid_nowrite2: got %b exp 0", ld_reg_store); else n_pass++;
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        src_valid  = '0;
        src_data   = '0;
        src_dest   = '0;
        src_ld_reg = '0;
        src_ld_cc  = '0;
        tick();
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_stall_fill();
        test_dropped();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
